// File: rtl/console_pkg.sv
// console_pkg: register offsets, STATUS bit positions and serializer states for wb_console
package console_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_CNT = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 frame shifter, each state/bit held DIV clocks, registered tx
module uart_tx_serializer
  import console_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       pop,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(DIV);
  ser_state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] sh;
  logic [2:0] bit_idx;
  logic last;
  assign last = cnt == CW'(DIV - 1);
  // a waiting byte is taken at the last STOP clock so frames run back to back
  assign pop = valid && (state == IDLE || (state == STOP && last));
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      bit_idx <= '0;
      tx <= 1'b1;
    end else if (pop) begin
      state <= START;
      cnt <= '0;
      sh <= data;
      tx <= 1'b0;
    end else if (state != IDLE) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last)
        case (state)
          START: begin
            state <= DATA;
            tx <= sh[0];
            sh <= sh >> 1;
            bit_idx <= '0;
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx <= 1'b1;
            end else begin
              tx <= sh[0];
              sh <= sh >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: rtl/wb_console.sv
// wb_console: Wishbone classic slave with a TX FIFO feeding a UART 8N1 serializer
module wb_console
  import console_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        tx
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, empty, busy, pop, req, data_wr, accept, push;
  logic [1:0] reg_sel;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = &{wb_adr[31:4], wb_adr[1:0], wb_dat_i[31:8], wb_sel[3:1]};
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign reg_sel = wb_adr[3:2];
  assign req = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
  assign data_wr = wb_we & (reg_sel == REG_DATA) & wb_sel[0];
  // a full FIFO still accepts when the serializer pops in the same cycle
  assign accept = req & (~data_wr | ~full | pop);
  assign push = accept & data_wr;
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_CNT+:5] = 5'(count);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_dat_i[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      wb_dat_o <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wb_ack <= accept & ~wb_adr[3];
      wb_err <= accept & wb_adr[3];
      wb_dat_o <= (accept & ~wb_we & (reg_sel == REG_STATUS)) ? status : '0;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  uart_tx_serializer #(.DIV(DIV)) u_ser (
    .clk(clk),
    .rst(rst),
    .data(mem[rd_ptr]),
    .valid(~empty),
    .pop(pop),
    .tx(tx),
    .busy(busy)
  );
endmodule

// File: tb/tb_wb_console.sv
// tb_wb_console: directed and random checks of wb_console against a byte-level UART receiver model
module tb_wb_console;
  logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0] sel = '0;
  logic [31:0] dat_o;
  logic ack, err, tx;
  int n_chk = 0, n_fail = 0, n_bad = 0, n_abort = 0, cycle = 0;
  logic [7:0] rx_q[$];
  int rx_t[$];

  wb_console #(.CLK_FREQ(8), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_dat_i(dat_i), .wb_sel(sel), .wb_dat_o(dat_o), .wb_ack(ack), .wb_err(err), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // receiver: samples mid-bit, drops frames cut by reset, flags bad start/stop bits
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        int t0;
        logic [7:0] b;
        logic bad, hit_rst;
        t0 = cycle;
        bad = 1'b0;
        hit_rst = 1'b0;
        repeat (3) begin @(negedge clk); hit_rst |= rst; end
        bad |= (tx !== 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (8) begin @(negedge clk); hit_rst |= rst; end
          b[i] = tx;
        end
        repeat (8) begin @(negedge clk); hit_rst |= rst; end
        bad |= (tx !== 1'b1);
        if (hit_rst) n_abort++;
        else if (bad) n_bad++;
        else begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic got_ack, output logic got_err, output int edges);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    edges = 0;
    while (!(ack | err) && edges < 500) begin
      @(posedge clk); #1;
      edges++;
    end
    got_ack = ack; got_err = err; rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("no_timeout", 32'(edges < 500), 1);
    @(posedge clk); #1;
    chk("resp_one_cycle", {ack, err, 30'(dat_o != 0)}, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic [3:0] s, output int edges);
    logic [31:0] rd;
    logic ga, ge;
    xfer(1'b1, a, {24'hABCDEF, d}, s, rd, ga, ge, edges);
    chk("wr_ack", {ga, ge}, 2'b10);
  endtask

  task automatic rd_status(output logic [31:0] v);
    logic ga, ge;
    int e;
    xfer(1'b0, 32'h4, 32'h0, 4'hF, v, ga, ge, e);
    chk("status_ack", {ga, ge}, 2'b10);
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 2000) begin @(posedge clk); #1; t++; end
    chk("rx_count", rx_q.size(), n);
  endtask

  initial begin
    logic [31:0] v, rd;
    logic ga, ge, all1;
    logic [9:0] frame;
    logic [7:0] exp_q[$];
    int e;
    @(posedge clk); #1;
    chk("reset_outputs", {tx, ack, err, 29'(dat_o != 0)}, 32'h8000_0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    rd_status(v);
    chk("status_after_reset", v, 32'h4);

    // single byte 0x41: exact line waveform, each level held 8 clocks
    frame = {1'b1, 8'h41, 1'b0};
    wr(32'h0, 8'h41, 4'h1, e);
    chk("wr41_latency", e, 1);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("tx41_bit%0d_first", j), tx, frame[j]);
      if (j < 9) begin
        repeat (7) begin @(posedge clk); #1; end
        chk($sformatf("tx41_bit%0d_last", j), tx, frame[j]);
        @(posedge clk); #1;
      end
    end
    rd_status(v);
    chk("status_busy_stop", v, 32'h5);
    repeat (20) begin @(posedge clk); #1; end
    rd_status(v);
    chk("status_idle", v, 32'h4);
    chk("rx41_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rx41_byte", rx_q[0], 8'h41);
    rx_q.delete(); rx_t.delete();

    // fill: one byte in the serializer plus four queued, the sixth waits for the next pop
    for (int i = 0; i < 5; i++) begin
      wr(32'h0, 8'(8'h30 + i), 4'h1, e);
      chk("fill_prompt_ack", e, 1);
    end
    wr(32'h0, 8'h35, 4'h1, e);
    chk("fill_stall_edges", e, 72);
    rd_status(v);
    chk("status_full", v, 32'h23);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, ga, ge, e);
    chk("unmapped_rd_resp", {ga, ge, 30'(rd != 0)}, 32'h4000_0000);
    xfer(1'b1, 32'hC, 32'h99, 4'hF, rd, ga, ge, e);
    chk("unmapped_wr_resp", {ga, ge}, 2'b01);
    rd_status(v);
    chk("status_after_err", v, 32'h23);
    wait_rx(6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      chk($sformatf("fill_byte%0d", i), rx_q[i], 8'(8'h30 + i));
      if (i > 0) chk($sformatf("fill_gap%0d", i), rx_t[i] - rx_t[i-1], 80);
    end
    repeat (20) begin @(posedge clk); #1; end
    rd_status(v);
    chk("status_drained", v, 32'h4);
    rx_q.delete(); rx_t.delete();

    // sel[0]=0: acknowledged but nothing queued or sent
    wr(32'h0, 8'h55, 4'b0010, e);
    rd_status(v);
    chk("sel0_status", v, 32'h4);
    all1 = 1'b1;
    repeat (100) begin @(posedge clk); #1; all1 &= (tx === 1'b1); end
    chk("sel0_tx_idle", all1, 1);
    chk("sel0_no_rx", rx_q.size(), 0);

    // random traffic: bytes with sel[0]=1 must come out in order, unmapped gets err
    for (int k = 0; k < 14; k++) begin
      logic [7:0] d;
      logic [3:0] s;
      d = 8'($urandom);
      s = 4'($urandom);
      if ($urandom_range(0, 9) < 2) begin
        xfer(1'($urandom), $urandom_range(0, 1) ? 32'h8 : 32'hC, {24'h0, d}, s, rd, ga, ge, e);
        chk("rand_err", {ga, ge}, 2'b01);
      end else begin
        wr(32'h0, d, s, e);
        if (s[0]) exp_q.push_back(d);
      end
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_rx(exp_q.size());
    repeat (100) @(posedge clk);
    #1;
    chk("rand_rx_total", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("rand_byte%0d", i), rx_q[i], exp_q[i]);
    rx_q.delete(); rx_t.delete();

    // reset during data bit 3 of 0x81 with two more bytes queued
    wr(32'h0, 8'h81, 4'h1, e);
    wr(32'h0, 8'h7E, 4'h1, e);
    wr(32'h0, 8'h18, 4'h1, e);
    repeat (31) begin @(posedge clk); #1; end
    chk("tx_bit3_before_rst", tx, 0);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {tx, ack, err}, 3'b100);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    all1 = 1'b1;
    repeat (300) begin @(posedge clk); #1; all1 &= (tx === 1'b1); end
    chk("rst_tx_idle", all1, 1);
    chk("rst_no_frames", rx_q.size(), 0);
    chk("rst_abort_seen", n_abort, 1);
    rd_status(v);
    chk("status_after_midrst", v, 32'h4);
    chk("framing_errors", n_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
